// File: rtl/cond_logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_logic_unit_pkg
//   Shared definitions for the condition-logic path. The ALU decoder and the
//   main decoder import this package too, so the encodings here are the
//   single source of truth for condition codes, FlagW bits and NZCV layout.
//
//   Contents:
//     COND_*      4-bit condition-field encodings (Instr[31:28])
//     FLAGW_*     bit indices inside the 2-bit FlagW bus
//     FLAG_*      bit positions inside the {N,Z,C,V} flag vector
//     ctrl_t      registered control bundle of the output stage
//     merge_flags helper applying FlagW enables to a flag vector
// ---------------------------------------------------------------------------
package cond_logic_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_write;
        logic cond_ex;
        logic illegal_cond;
    } ctrl_t;

    // N,Z travel together and C,V travel together; each pair is replaced
    // only when its FlagW enable is set.
    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] alu,
                                               input logic [1:0] flag_w);
        logic [3:0] res;
        res = cur;
        if (flag_w[FLAGW_NZ]) begin
            res[FLAG_N] = alu[FLAG_N];
            res[FLAG_Z] = alu[FLAG_Z];
        end
        if (flag_w[FLAGW_CV]) begin
            res[FLAG_C] = alu[FLAG_C];
            res[FLAG_V] = alu[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_logic_unit_if.sv
// ---------------------------------------------------------------------------
// cond_logic_unit_if
//   Bundles the decoder-side requests and the registered, condition-gated
//   controls of cond_logic_unit. clk and rst_n stay as plain module ports.
//
//   Decoder side (master drives):
//     in_valid, stall, cond[3:0], alu_flags[3:0], flag_w[1:0], pcs, reg_w, mem_w
//   Unit side (slave drives):
//     out_valid, pc_src, reg_write, mem_write, cond_ex, illegal_cond,
//     flags[3:0], exec_cnt[CNT_W-1:0], skip_cnt[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface cond_logic_unit_if #(
    parameter int CNT_W = 16
);
    import cond_logic_unit_pkg::*;

    logic             in_valid;
    logic             stall;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs;
    logic             reg_w;
    logic             mem_w;

    logic             out_valid;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic             cond_ex;
    logic             illegal_cond;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] skip_cnt;

    modport master (
        output in_valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
        input  out_valid, pc_src, reg_write, mem_write, cond_ex, illegal_cond,
               flags, exec_cnt, skip_cnt
    );

    modport slave (
        input  in_valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
        output out_valid, pc_src, reg_write, mem_write, cond_ex, illegal_cond,
               flags, exec_cnt, skip_cnt
    );

endinterface

// File: rtl/cond_logic_unit_cond_check.sv
// ---------------------------------------------------------------------------
// cond_logic_unit_cond_check
//   Purely combinational evaluation of a 4-bit condition field against the
//   architectural {N,Z,C,V} flags.
//
//   Ports:
//     cond_i     condition field of the current instruction
//     flags_i    registered NZCV flags
//     cond_ex_o  1 when the instruction must execute
//     illegal_o  1 when cond_i is the reserved 4'b1111 encoding
// ---------------------------------------------------------------------------
module cond_logic_unit_cond_check
    import cond_logic_unit_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o,
    output logic       illegal_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned and infers a latch.
    always_comb begin
        cond_ex_o = 1'b0;
        illegal_o = 1'b0;
        unique case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = ~(n ^ v);
            COND_LT: cond_ex_o = n ^ v;
            COND_GT: cond_ex_o = ~z & ~(n ^ v);
            COND_LE: cond_ex_o = z | (n ^ v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: illegal_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// ---------------------------------------------------------------------------
// cond_logic_unit
//   Gates the main decoder's write/branch requests with the instruction's
//   condition field, owns the NZCV flag register and keeps saturating debug
//   counts of executed and skipped instructions. All gated controls leave
//   through a single register stage (one cycle after accept).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous reset, active low
//     bus    cond_logic_unit_if.slave (requests in, registered controls,
//            flags and counters out)
//
//   Parameter CNT_W: debug counter width, at least 2.
// ---------------------------------------------------------------------------
module cond_logic_unit
    import cond_logic_unit_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input logic            clk,
    input logic            rst_n,
    cond_logic_unit_if.slave bus
);

    logic [3:0]       flags_q,    flags_d;
    logic             valid_q,    valid_d;
    ctrl_t            ctrl_q,     ctrl_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    logic cond_ex_c;
    logic illegal_c;

    // The condition is evaluated on the registered flags, so an instruction
    // sees the flags written by the one accepted just before it.
    cond_logic_unit_cond_check u_cond_check (
        .cond_i    (bus.cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex_c),
        .illegal_o (illegal_c)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    always_comb begin
        flags_d    = flags_q;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;

        // A stall freezes everything, including the pending output.
        if (!bus.stall) begin
            if (bus.in_valid) begin
                valid_d             = 1'b1;
                ctrl_d.pc_src       = bus.pcs   & cond_ex_c;
                ctrl_d.reg_write    = bus.reg_w & cond_ex_c;
                ctrl_d.mem_write    = bus.mem_w & cond_ex_c;
                ctrl_d.cond_ex      = cond_ex_c;
                ctrl_d.illegal_cond = illegal_c;
                if (cond_ex_c) begin
                    flags_d    = merge_flags(flags_q, bus.alu_flags, bus.flag_w);
                    exec_cnt_d = sat_inc(exec_cnt_q);
                end else begin
                    skip_cnt_d = sat_inc(skip_cnt_q);
                end
            end else begin
                // Bubble: drop every write request so nothing stale repeats.
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; reset is synchronous, so it only acts on
    // a clock edge and overrides stall and in_valid there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            flags_q    <= flags_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.pc_src       = ctrl_q.pc_src;
    assign bus.reg_write    = ctrl_q.reg_write;
    assign bus.mem_write    = ctrl_q.mem_write;
    assign bus.cond_ex      = ctrl_q.cond_ex;
    assign bus.illegal_cond = ctrl_q.illegal_cond;
    assign bus.flags        = flags_q;
    assign bus.exec_cnt     = exec_cnt_q;
    assign bus.skip_cnt     = skip_cnt_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_logic_unit
//   Two instances (16-bit and 2-bit counters) share one stimulus stream.
//   A behavioural model tracks the expected state of each; a negedge process
//   compares both DUTs against it every cycle after the first reset, and the
//   directed opening phase also checks hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_cond_logic_unit;
    import cond_logic_unit_pkg::*;

    localparam int W_A = 16;
    localparam int W_B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, stall, pcs, reg_w, mem_w;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cond_logic_unit_if #(.CNT_W(W_A)) bus_a ();
    cond_logic_unit_if #(.CNT_W(W_B)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.stall     = stall;
    assign bus_a.cond      = cond;
    assign bus_a.alu_flags = alu_flags;
    assign bus_a.flag_w    = flag_w;
    assign bus_a.pcs       = pcs;
    assign bus_a.reg_w     = reg_w;
    assign bus_a.mem_w     = mem_w;

    assign bus_b.in_valid  = in_valid;
    assign bus_b.stall     = stall;
    assign bus_b.cond      = cond;
    assign bus_b.alu_flags = alu_flags;
    assign bus_b.flag_w    = flag_w;
    assign bus_b.pcs       = pcs;
    assign bus_b.reg_w     = reg_w;
    assign bus_b.mem_w     = mem_w;

    cond_logic_unit #(.CNT_W(W_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    cond_logic_unit #(.CNT_W(W_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // ---------------------------------------------------------------- model
    typedef struct {
        bit       valid;
        bit       pc_src;
        bit       reg_write;
        bit       mem_write;
        bit       cond_ex;
        bit       illegal;
        bit [3:0] flags;
        int       exec_cnt;
        int       skip_cnt;
    } model_t;

    model_t m_a, m_b;
    bit     started = 1'b0;

    // Condition codes come in pairs: bit 0 inverts the base test chosen by
    // bits 3:1; 1111 never executes.
    function automatic bit cond_holds(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic model_t model_step(input model_t m, input int cnt_max);
        model_t r;
        bit     ok;
        r = m;
        if (!rst_n) begin
            r = '{default: 0};
        end else if (!stall) begin
            if (in_valid) begin
                ok          = cond_holds(cond, m.flags);
                r.valid     = 1'b1;
                r.pc_src    = pcs   && ok;
                r.reg_write = reg_w && ok;
                r.mem_write = mem_w && ok;
                r.cond_ex   = ok;
                r.illegal   = (cond == 4'hF);
                if (ok) begin
                    if (flag_w[1]) r.flags[3:2] = alu_flags[3:2];
                    if (flag_w[0]) r.flags[1:0] = alu_flags[1:0];
                    if (r.exec_cnt < cnt_max) r.exec_cnt = r.exec_cnt + 1;
                end else begin
                    if (r.skip_cnt < cnt_max) r.skip_cnt = r.skip_cnt + 1;
                end
            end else begin
                r.valid     = 1'b0;
                r.pc_src    = 1'b0;
                r.reg_write = 1'b0;
                r.mem_write = 1'b0;
                r.cond_ex   = 1'b0;
                r.illegal   = 1'b0;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_a <= model_step(m_a, (1 << W_A) - 1);
        m_b <= model_step(m_b, (1 << W_B) - 1);
        if (!rst_n) started <= 1'b1;
    end

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic compare_one(input string tag, input model_t m,
                               input logic ov, input logic pc, input logic rw,
                               input logic mw, input logic cx, input logic il,
                               input logic [3:0] fl, input logic [31:0] ec,
                               input logic [31:0] sc);
        check({tag, ".out_valid"}, 32'(ov), 32'(m.valid));
        check({tag, ".pc_src"},    32'(pc), 32'(m.pc_src));
        check({tag, ".reg_write"}, 32'(rw), 32'(m.reg_write));
        check({tag, ".mem_write"}, 32'(mw), 32'(m.mem_write));
        check({tag, ".cond_ex"},   32'(cx), 32'(m.cond_ex));
        if (m.valid) check({tag, ".illegal_cond"}, 32'(il), 32'(m.illegal));
        check({tag, ".flags"},     32'(fl), 32'(m.flags));
        check({tag, ".exec_cnt"},  ec, 32'(m.exec_cnt));
        check({tag, ".skip_cnt"},  sc, 32'(m.skip_cnt));
    endtask

    always @(negedge clk) begin
        if (started) begin
            compare_one("a", m_a, bus_a.out_valid, bus_a.pc_src, bus_a.reg_write,
                        bus_a.mem_write, bus_a.cond_ex, bus_a.illegal_cond,
                        bus_a.flags, 32'(bus_a.exec_cnt), 32'(bus_a.skip_cnt));
            compare_one("b", m_b, bus_b.out_valid, bus_b.pc_src, bus_b.reg_write,
                        bus_b.mem_write, bus_b.cond_ex, bus_b.illegal_cond,
                        bus_b.flags, 32'(bus_b.exec_cnt), 32'(bus_b.skip_cnt));
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] c,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic rw, input logic mw);
        in_valid  = v;
        stall     = s;
        cond      = c;
        alu_flags = af;
        flag_w    = fw;
        pcs       = p;
        reg_w     = rw;
        mem_w     = mw;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 0, COND_AL, 4'b1111, 2'b11, 1, 1, 1);
        tick();
        tick();
        check("rst.out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst.flags",     32'(bus_a.flags),     32'd0);
        check("rst.reg_write", 32'(bus_a.reg_write), 32'd0);
        check("rst.exec_cnt",  32'(bus_a.exec_cnt),  32'd0);

        // AL with full flag write
        rst_n = 1'b1;
        drive(1, 0, COND_AL, 4'b0100, 2'b11, 0, 1, 0);
        tick();
        check("al.reg_write", 32'(bus_a.reg_write), 32'd1);
        check("al.cond_ex",   32'(bus_a.cond_ex),   32'd1);
        check("al.flags",     32'(bus_a.flags),     32'h4);
        check("al.exec_cnt",  32'(bus_a.exec_cnt),  32'd1);

        // NE with Z set: skipped, flags untouched
        drive(1, 0, COND_NE, 4'b1000, 2'b11, 0, 0, 1);
        tick();
        check("ne.mem_write", 32'(bus_a.mem_write), 32'd0);
        check("ne.flags",     32'(bus_a.flags),     32'h4);
        check("ne.skip_cnt",  32'(bus_a.skip_cnt),  32'd1);

        // Clear flags, then write only N,Z, then LT sees N!=V
        drive(1, 0, COND_AL, 4'b0000, 2'b11, 0, 0, 0);
        tick();
        check("clr.flags", 32'(bus_a.flags), 32'h0);
        drive(1, 0, COND_AL, 4'b1111, 2'b10, 0, 0, 0);
        tick();
        check("nz.flags", 32'(bus_a.flags), 32'hC);
        drive(1, 0, COND_LT, 4'b0000, 2'b00, 0, 0, 0);
        tick();
        check("lt.cond_ex", 32'(bus_a.cond_ex), 32'd1);
        check("lt.flags",   32'(bus_a.flags),   32'hC);

        // Stall three cycles, then release
        drive(1, 1, COND_AL, 4'b0010, 2'b11, 0, 0, 0);
        tick();
        tick();
        tick();
        check("stall.flags",    32'(bus_a.flags),    32'hC);
        check("stall.exec_cnt", 32'(bus_a.exec_cnt), 32'd4);
        check("stall.cond_ex",  32'(bus_a.cond_ex),  32'd1);
        stall = 1'b0;
        tick();
        check("unstall.flags",    32'(bus_a.flags),    32'h2);
        check("unstall.exec_cnt", 32'(bus_a.exec_cnt), 32'd5);

        // Reserved condition
        drive(1, 0, COND_NV, 4'b1111, 2'b11, 1, 0, 0);
        tick();
        check("nv.pc_src",       32'(bus_a.pc_src),       32'd0);
        check("nv.illegal_cond", 32'(bus_a.illegal_cond), 32'd1);
        check("nv.skip_cnt",     32'(bus_a.skip_cnt),     32'd2);
        check("nv.flags",        32'(bus_a.flags),        32'h2);

        // Five executed instructions saturate the 2-bit counter
        check("sat.exec_cnt_b", 32'(bus_b.exec_cnt), 32'd3);
        check("sat.skip_cnt_b", 32'(bus_b.skip_cnt), 32'd2);

        // Bubble clears the controls
        drive(0, 0, COND_AL, 4'b0000, 2'b11, 1, 1, 1);
        tick();
        check("idle.out_valid", 32'(bus_a.out_valid), 32'd0);
        check("idle.reg_write", 32'(bus_a.reg_write), 32'd0);
        check("idle.flags",     32'(bus_a.flags),     32'h2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive(logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 4) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)));
            tick();
        end

        // Reset with a valid instruction present
        rst_n = 1'b1;
        drive(1, 0, COND_AL, 4'b1111, 2'b11, 1, 1, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("fin.out_valid", 32'(bus_a.out_valid), 32'd0);
        check("fin.pc_src",    32'(bus_a.pc_src),    32'd0);
        check("fin.cond_ex",   32'(bus_a.cond_ex),   32'd0);
        check("fin.flags",     32'(bus_a.flags),     32'h0);
        check("fin.exec_cnt",  32'(bus_a.exec_cnt),  32'd0);
        check("fin.skip_cnt",  32'(bus_a.skip_cnt),  32'd0);
        check("fin.exec_cnt_b", 32'(bus_b.exec_cnt), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
